// File: rtl/spiker_result_packer.sv
// spiker_result_packer
//
// Gathers the spiker core's output spikes, which arrive as IN_WIDTH-bit chunks
// over a valid/ready handshake, into one DATA_WIDTH-bit result vector. When the
// frame is complete, it raises a one-cycle sample strobe for the downstream
// stage that loads the spikes_result register fields.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset (overrides all inputs)
//   start_i      one-cycle pulse: clear the result and begin a new frame
//   spk_valid_i  input beat valid
//   spk_ready_o  beat can be accepted (high only while filling)
//   spk_data_i   spike chunk; beat k lands in data_o[k*IN_WIDTH +: IN_WIDTH]
//   spk_last_i   final beat of the frame (early last -> len_err_o)
//   data_o       packed result vector; held until the next start or reset
//   sample_o     one-cycle strobe; data_o is complete in that cycle
//   busy_o       frame in progress (FILL or DONE)
//   len_err_o    sticky: the frame ended before N_BEATS beats
module spiker_result_packer #(
  parameter int WIDTH      = 32,
  parameter int N_REG      = 24,
  parameter int DATA_WIDTH = 768,
  parameter int IN_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  spk_valid_i,
  output logic                  spk_ready_o,
  input  logic [IN_WIDTH-1:0]   spk_data_i,
  input  logic                  spk_last_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sample_o,
  output logic                  busy_o,
  output logic                  len_err_o
);

  localparam int N_BEATS = DATA_WIDTH / IN_WIDTH;
  localparam int CNT_W   = $clog2(N_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  if (DATA_WIDTH % IN_WIDTH != 0) begin : g_bad_in_width
    $error("spiker_result_packer: DATA_WIDTH must be a multiple of IN_WIDTH");
  end
  if (DATA_WIDTH != WIDTH * N_REG) begin : g_bad_data_width
    $error("spiker_result_packer: DATA_WIDTH must equal WIDTH*N_REG");
  end

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    len_err_q;
  logic                    beat_acc;
  logic                    frame_end;

  // Ready is high exactly in FILL, so a handshake is valid while in FILL.
  assign beat_acc  = spk_valid_i && (state_q == FILL);
  assign frame_end = (cnt_q == LAST_BEAT) || spk_last_i;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // paths that are not covered hold nothing and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_i) state_d = FILL;
      FILL: begin
        if (start_i)                    state_d = FILL;
        else if (beat_acc && frame_end) state_d = DONE;
      end
      DONE:    state_d = start_i ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples values from before the edge, regardless of process order.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // start_i has priority over a beat in the same cycle. This drops a beat that
  // collides with a restart, and it lets a start in DONE clear the result at the
  // edge that ends the sample cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the result vector is reset on purpose, because downstream
      // sees data_o = 0 after reset. It is a register bank, not a memory macro.
      data_q    <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else if (start_i) begin
      data_q    <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else if (beat_acc) begin
      data_q[cnt_q*IN_WIDTH +: IN_WIDTH] <= spk_data_i;
      // FILL exits at LAST_BEAT, so the counter is never advanced past it.
      if (cnt_q != LAST_BEAT) cnt_q <= cnt_q + CNT_W'(1);
      if (spk_last_i && (cnt_q != LAST_BEAT)) len_err_q <= 1'b1;
    end
  end

  // All outputs are decoded from registered state, so there is no
  // combinational path from the inputs.
  assign spk_ready_o = (state_q == FILL);
  assign sample_o    = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign data_o      = data_q;
  assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_spiker_result_packer.sv
// Directed bench for spiker_result_packer: reset, full frame, random valid
// gaps, early last, restart mid-frame, reset mid-frame, back-to-back frames.
module tb_spiker_result_packer;

  localparam int DW = 768;
  localparam int HW = DW / 2;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          spk_valid_i = 1'b0;
  logic          spk_ready_o;
  logic [7:0]    spk_data_i = '0;
  logic          spk_last_i = 1'b0;
  logic [DW-1:0] data_o;
  logic          sample_o;
  logic          busy_o;
  logic          len_err_o;

  int n_vec  = 0;
  int n_miss = 0;
  int pulses = 0;

  logic [DW-1:0] exp_idx;
  logic [DW-1:0] exp_early;
  logic [DW-1:0] zero_vec;

  spiker_result_packer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .spk_valid_i(spk_valid_i),
    .spk_ready_o(spk_ready_o),
    .spk_data_i (spk_data_i),
    .spk_last_i (spk_last_i),
    .data_o     (data_o),
    .sample_o   (sample_o),
    .busy_o     (busy_o),
    .len_err_o  (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (sample_o) pulses++;
  endtask

  task automatic check(input string tag, input logic [HW-1:0] obs,
                       input logic [HW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] exp);
    check({tag, "_lo"}, data_o[HW-1:0], exp[HW-1:0]);
    check({tag, "_hi"}, data_o[DW-1:HW], exp[DW-1:HW]);
  endtask

  // Send n consecutive beats. The data is the beat index or a fixed pattern.
  task automatic send_beats(input int n, input logic [7:0] pat,
                            input bit use_index, input bit last_on_final);
    for (int k = 0; k < n; k++) begin
      spk_valid_i = 1'b1;
      spk_data_i  = use_index ? 8'(k) : pat;
      spk_last_i  = last_on_final && (k == n - 1);
      tick();
    end
    spk_valid_i = 1'b0;
    spk_last_i  = 1'b0;
    spk_data_i  = 8'hEE;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int k;
    int cyc;
    logic rdy;
    logic v;

    zero_vec  = '0;
    exp_idx   = '0;
    exp_early = '0;
    for (int i = 0; i < 96; i++) exp_idx[i*8 +: 8] = 8'(i);
    for (int i = 0; i < 11; i++) exp_early[i*8 +: 8] = 8'hAA;

    // Reset state
    tick(); tick();
    rst_i = 1'b0;
    check("rst_ready",   HW'(spk_ready_o), HW'(0));
    check("rst_sample",  HW'(sample_o),    HW'(0));
    check("rst_busy",    HW'(busy_o),      HW'(0));
    check("rst_len_err", HW'(len_err_o),   HW'(0));
    check_data("rst_data", zero_vec);

    // Full frame, no gaps
    pulse_start();
    check("ff_ready_after_start", HW'(spk_ready_o), HW'(1));
    check("ff_busy", HW'(busy_o), HW'(1));
    pulses = 0;
    send_beats(96, 8'h00, 1'b1, 1'b1);
    check("ff_sample", HW'(sample_o), HW'(1));
    check("ff_ready_done", HW'(spk_ready_o), HW'(0));
    check("ff_byte0", HW'(data_o[7:0]), HW'(8'h00));
    check("ff_byte1", HW'(data_o[15:8]), HW'(8'h01));
    check("ff_byte95", HW'(data_o[767:760]), HW'(8'h5F));
    check("ff_len_err", HW'(len_err_o), HW'(0));
    check_data("ff_data", exp_idx);
    tick();
    check("ff_sample_drop", HW'(sample_o), HW'(0));
    check("ff_idle_busy", HW'(busy_o), HW'(0));
    check("ff_pulses", HW'(pulses), HW'(1));

    // Random valid gaps
    pulse_start();
    pulses = 0;
    k = 0;
    cyc = 0;
    while (k < 96 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      spk_valid_i = v;
      spk_data_i  = v ? 8'(k) : 8'hEE;
      spk_last_i  = v && (k == 95);
      rdy = spk_ready_o;
      tick();
      if (v && rdy) k++;
      cyc++;
    end
    spk_valid_i = 1'b0;
    spk_last_i  = 1'b0;
    check("gap_beats", HW'(k), HW'(96));
    check("gap_sample", HW'(sample_o), HW'(1));
    check_data("gap_data", exp_idx);
    tick();
    check("gap_pulses", HW'(pulses), HW'(1));

    // Early last: an all-0xFF frame first, then last on beat 10
    pulse_start();
    send_beats(96, 8'hFF, 1'b0, 1'b0);
    tick();
    pulse_start();
    pulses = 0;
    send_beats(11, 8'hAA, 1'b0, 1'b1);
    check("el_sample", HW'(sample_o), HW'(1));
    check("el_len_err", HW'(len_err_o), HW'(1));
    check_data("el_data", exp_early);
    tick(); tick(); tick();
    check("el_len_err_sticky", HW'(len_err_o), HW'(1));
    check("el_pulses", HW'(pulses), HW'(1));
    pulse_start();
    check("el_len_err_clr", HW'(len_err_o), HW'(0));

    // Restart mid-frame, with a beat handshaken alongside start
    pulses = 0;
    send_beats(40, 8'h11, 1'b0, 1'b0);
    start_i     = 1'b1;
    spk_valid_i = 1'b1;
    spk_data_i  = 8'h77;
    tick();
    start_i     = 1'b0;
    spk_valid_i = 1'b0;
    check("rs_no_sample", HW'(sample_o), HW'(0));
    check("rs_ready", HW'(spk_ready_o), HW'(1));
    check_data("rs_cleared", zero_vec);
    send_beats(96, 8'h00, 1'b1, 1'b1);
    check("rs_sample", HW'(sample_o), HW'(1));
    check_data("rs_data", exp_idx);
    tick();
    check("rs_pulses", HW'(pulses), HW'(1));

    // Reset mid-frame
    pulse_start();
    send_beats(50, 8'h33, 1'b0, 1'b0);
    rst_i       = 1'b1;
    spk_valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rm_ready", HW'(spk_ready_o), HW'(0));
    check("rm_busy", HW'(busy_o), HW'(0));
    check("rm_sample", HW'(sample_o), HW'(0));
    check("rm_len_err", HW'(len_err_o), HW'(0));
    check_data("rm_data", zero_vec);
    spk_data_i = 8'h44;
    tick(); tick(); tick();
    spk_valid_i = 1'b0;
    check("rm_still_idle", HW'(busy_o), HW'(0));
    check_data("rm_no_accept", zero_vec);

    // Back-to-back frames: start in the DONE cycle
    pulse_start();
    send_beats(96, 8'h00, 1'b1, 1'b1);
    check("bb_sample", HW'(sample_o), HW'(1));
    check_data("bb_old_data", exp_idx);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("bb_ready", HW'(spk_ready_o), HW'(1));
    check("bb_sample_off", HW'(sample_o), HW'(0));
    check_data("bb_cleared", zero_vec);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
